// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the operand-fetch stage.
//   XLEN      operand / writeback data width
//   REG_AW    register address width (32 registers)
//   REG_ZERO  index of the hard-wired zero register x0
//   opf_state_t  operand-fetch FSM states
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } opf_state_t;

endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: decode-side and execute-side handshakes of the operand-fetch stage.
//   in_valid/in_ready, in_pc, in_rs1, in_rs2, in_rd         decode -> stage
//   out_valid/out_ready, out_pc, out_rd, out_rs1/2_data     stage -> execute
// master: the surrounding pipeline (drives decode inputs and execute ready).
// slave:  operand_fetch itself.
interface operand_fetch_if;
  import cpu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [REG_AW-1:0] in_rs1;
  logic [REG_AW-1:0] in_rs2;
  logic [REG_AW-1:0] in_rd;

  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [REG_AW-1:0] out_rd;
  logic [XLEN-1:0]   out_rs1_data;
  logic [XLEN-1:0]   out_rs2_data;

  modport master (
    output in_valid, in_pc, in_rs1, in_rs2, in_rd, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1_data, out_rs2_data
  );

  modport slave (
    input  in_valid, in_pc, in_rs1, in_rs2, in_rd, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1_data, out_rs2_data
  );

endinterface

// File: rtl/opf_operand_sel.sv
// opf_operand_sel: per-operand priority mux.
//   rs        held source register index
//   wr_now    a non-x0 writeback is happening this cycle
//   wb_rd     writeback destination
//   wb_data   writeback data
//   fallback  value used when neither x0 nor a forward applies
//   result    selected operand
// Priority: x0 -> 0, matching writeback -> wb_data, otherwise fallback.
module opf_operand_sel
  import cpu_pkg::*;
(
  input  logic [REG_AW-1:0] rs,
  input  logic              wr_now,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic [XLEN-1:0]   fallback,
  output logic [XLEN-1:0]   result
);

  always_comb begin
    result = fallback;
    if (rs == REG_ZERO) begin
      result = '0;
    end else if (wr_now && (wb_rd == rs)) begin
      result = wb_data;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: operand-fetch stage between decode and execute.
//   clock, reset_n         clock and asynchronous active-low reset
//   bus (slave)            decode/execute handshakes, see operand_fetch_if
//   rf_addr_rs1/2          register-file read addresses
//   rf_data_rs1/2          register-file read data (1-cycle synchronous read)
//   wb_valid/wb_rd/wb_data writeback port (wb_valid is also the RF write enable)
//   perf_retry_count       only with OPFETCH_PERF_EN: saturating count of retried reads
// The register file drops its read on any cycle with a non-x0 write, so a read
// issued in such a cycle is re-issued from WAIT until one goes through.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  operand_fetch_if.slave    bus,
  output logic [REG_AW-1:0] rf_addr_rs1,
  output logic [REG_AW-1:0] rf_addr_rs2,
  input  logic [XLEN-1:0]   rf_data_rs1,
  input  logic [XLEN-1:0]   rf_data_rs2,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data
`ifdef OPFETCH_PERF_EN
  ,
  output logic [31:0]       perf_retry_count
`endif
);

  opf_state_t        state_q;
  logic [XLEN-1:0]   pc_q;
  logic [REG_AW-1:0] rd_q;
  logic [REG_AW-1:0] rs1_q;
  logic [REG_AW-1:0] rs2_q;
  logic              supp_q;
  logic [XLEN-1:0]   rs1_data_q;
  logic [XLEN-1:0]   rs2_data_q;

  logic              wr_now;
  logic              accept;
  logic [XLEN-1:0]   rs1_fallback;
  logic [XLEN-1:0]   rs2_fallback;
  logic [XLEN-1:0]   rs1_sel;
  logic [XLEN-1:0]   rs2_sel;

  assign wr_now       = wb_valid && (wb_rd != REG_ZERO);
  assign bus.in_ready = (state_q == IDLE) || ((state_q == VALID) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign rf_addr_rs1 = accept ? bus.in_rs1 : rs1_q;
  assign rf_addr_rs2 = accept ? bus.in_rs2 : rs2_q;

  // In WAIT the mux captures from the RF; in VALID it falls back to the held
  // operand, so the same mux implements the writeback snoop.
  assign rs1_fallback = (state_q == WAIT) ? rf_data_rs1 : rs1_data_q;
  assign rs2_fallback = (state_q == WAIT) ? rf_data_rs2 : rs2_data_q;

  opf_operand_sel u_sel_rs1 (
    .rs       (rs1_q),
    .wr_now   (wr_now),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fallback (rs1_fallback),
    .result   (rs1_sel)
  );

  opf_operand_sel u_sel_rs2 (
    .rs       (rs2_q),
    .wr_now   (wr_now),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .fallback (rs2_fallback),
    .result   (rs2_sel)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_q       <= '0;
      rd_q       <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      supp_q     <= 1'b0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
    end else if (accept) begin
      pc_q    <= bus.in_pc;
      rd_q    <= bus.in_rd;
      rs1_q   <= bus.in_rs1;
      rs2_q   <= bus.in_rs2;
      supp_q  <= wr_now;
      state_q <= WAIT;
    end else begin
      unique case (state_q)
        WAIT: begin
          if (supp_q) begin
            // Previous read was dropped by the RF: addresses are re-presented.
            supp_q <= wr_now;
          end else begin
            rs1_data_q <= rs1_sel;
            rs2_data_q <= rs2_sel;
            state_q    <= VALID;
          end
        end
        VALID: begin
          rs1_data_q <= rs1_sel;
          rs2_data_q <= rs2_sel;
          if (bus.out_ready) begin
            state_q <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.out_valid    = (state_q == VALID);
  assign bus.out_pc       = pc_q;
  assign bus.out_rd       = rd_q;
  assign bus.out_rs1_data = rs1_data_q;
  assign bus.out_rs2_data = rs2_data_q;

`ifdef OPFETCH_PERF_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      perf_retry_count <= '0;
    end else if ((state_q == WAIT) && supp_q && (perf_retry_count != 32'hFFFF_FFFF)) begin
      perf_retry_count <= perf_retry_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: directed, scoreboard-based bench for operand_fetch.
// Includes a behavioural register file that drops reads on non-x0 write cycles.
module tb_operand_fetch;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  operand_fetch_if bus ();

  logic [4:0]  rf_addr_rs1, rf_addr_rs2;
  logic [31:0] rf_data_rs1, rf_data_rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef OPFETCH_PERF_EN
  logic [31:0] perf_retry_count;
`endif

  operand_fetch dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .rf_addr_rs1 (rf_addr_rs1),
    .rf_addr_rs2 (rf_addr_rs2),
    .rf_data_rs1 (rf_data_rs1),
    .rf_data_rs2 (rf_data_rs2),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
`ifdef OPFETCH_PERF_EN
    ,
    .perf_retry_count (perf_retry_count)
`endif
  );

  // Register file: synchronous read, read skipped on any non-x0 write cycle.
  function automatic logic [31:0] rf_init(input int i);
    case (i)
      0:       return 32'h5A5A_5A5A;
      3:       return 32'h0000_0011;
      4:       return 32'h0000_0022;
      9:       return 32'h0000_0999;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  logic [31:0] rf [32];
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= rf_init(i);
    end else if (wb_valid && (wb_rd != 5'd0)) begin
      rf[wb_rd] <= wb_data;
    end else begin
      rf_data_rs1 <= rf[rf_addr_rs1];
      rf_data_rs2 <= rf[rf_addr_rs2];
    end
  end

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic present(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd);
    bus.in_valid = 1'b1;
    bus.in_pc    = pc;
    bus.in_rs1   = rs1;
    bus.in_rs2   = rs2;
    bus.in_rd    = rd;
  endtask

  task automatic push_exp(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] a,
                          input logic [31:0] b);
    exp_t e;
    e.pc = pc;
    e.rd = rd;
    e.a  = a;
    e.b  = b;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    check({tag, "_sb_avail"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_pc"}, bus.out_pc, e.pc);
      check({tag, "_rd"}, 32'(bus.out_rd), 32'(e.rd));
      check({tag, "_rs1_data"}, bus.out_rs1_data, e.a);
      check({tag, "_rs2_data"}, bus.out_rs2_data, e.b);
    end
  endtask

  // Called in the accept cycle; counts cycles until out_valid (bounded).
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 10) begin
      tick();
      lat++;
      if (lat == 1) begin
        bus.in_valid = 1'b0;
        wb_valid     = 1'b0;
      end
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask

  logic [31:0] t6_pc [3];
  logic [4:0]  t6_rs1 [3];
  logic [4:0]  t6_rs2 [3];
  logic [31:0] t6_a [3];
  logic [31:0] t6_b [3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int cyc;
    int last;
    int n_out;

    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_rs1    = '0;
    bus.in_rs2    = '0;
    bus.in_rd     = '0;
    bus.out_ready = 1'b1;
    wb_valid      = 1'b0;
    wb_rd         = '0;
    wb_data       = '0;

    // Reset state
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_rd", 32'(bus.out_rd), 32'd0);
    check("rst_rs1_data", bus.out_rs1_data, 32'd0);
    check("rst_rs2_data", bus.out_rs2_data, 32'd0);
    check("rst_rf_addr_rs1", 32'(rf_addr_rs1), 32'd0);
`ifdef OPFETCH_PERF_EN
    check("rst_perf", perf_retry_count, 32'd0);
`endif
    reset_n = 1'b1;
    tick();

    // T1: plain fetch, 2-cycle latency
    present(32'h100, 5'd3, 5'd4, 5'd5);
    push_exp(32'h100, 5'd5, 32'h11, 32'h22);
    #1;
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);
    check("t1_rf_addr_rs1", 32'(rf_addr_rs1), 32'd3);
    check("t1_rf_addr_rs2", 32'(rf_addr_rs2), 32'd4);
    wait_valid("t1", 2);
    pop_check("t1");
    tick();
    check("t1_idle", 32'(bus.out_valid), 32'd0);

    // T2: writeback in accept cycle forces one retry
    present(32'h104, 5'd3, 5'd4, 5'd8);
    wb_valid = 1'b1;
    wb_rd    = 5'd7;
    wb_data  = 32'h77;
    push_exp(32'h104, 5'd8, 32'h11, 32'h22);
    #1;
    wait_valid("t2", 3);
    pop_check("t2");
`ifdef OPFETCH_PERF_EN
    check("t2_perf", perf_retry_count, 32'd1);
`endif
    tick();

    // T3: rs1==rs2 forwarded from writeback in capture cycle
    present(32'h108, 5'd9, 5'd9, 5'd10);
    push_exp(32'h108, 5'd10, 32'hDEAD, 32'hDEAD);
    #1;
    tick();
    bus.in_valid = 1'b0;
    wb_valid     = 1'b1;
    wb_rd        = 5'd9;
    wb_data      = 32'hDEAD;
    #1;
    check("t3_wait", 32'(bus.out_valid), 32'd0);
    tick();
    wb_valid = 1'b0;
    check("t3_valid", 32'(bus.out_valid), 32'd1);
    pop_check("t3");
    tick();

    // T4: rs1=x0 reads as zero; x0 writeback causes no retry
    present(32'h10C, 5'd0, 5'd4, 5'd11);
    wb_valid = 1'b1;
    wb_rd    = 5'd0;
    wb_data  = 32'hFFFF;
    push_exp(32'h10C, 5'd11, 32'h0, 32'h22);
    #1;
    wait_valid("t4", 2);
    pop_check("t4");
`ifdef OPFETCH_PERF_EN
    check("t4_perf", perf_retry_count, 32'd1);
`endif
    tick();

    // T5: stall in VALID with snoop update of rs2
    bus.out_ready = 1'b0;
    present(32'h200, 5'd3, 5'd4, 5'd6);
    push_exp(32'h200, 5'd6, 32'h11, 32'hBEEF);
    #1;
    wait_valid("t5", 2);
    check("t5_pre_rs2", bus.out_rs2_data, 32'h22);
    check("t5_in_ready_stall", 32'(bus.in_ready), 32'd0);
    tick();
    check("t5_hold1_valid", 32'(bus.out_valid), 32'd1);
    wb_valid = 1'b1;
    wb_rd    = 5'd4;
    wb_data  = 32'hBEEF;
    tick();
    wb_valid = 1'b0;
    check("t5_hold2_valid", 32'(bus.out_valid), 32'd1);
    check("t5_snoop_rs2", bus.out_rs2_data, 32'hBEEF);
    check("t5_hold_pc", bus.out_pc, 32'h200);
    check("t5_hold_rd", 32'(bus.out_rd), 32'd6);
    bus.out_ready = 1'b1;
    #1;
    check("t5_in_ready_release", 32'(bus.in_ready), 32'd1);
    pop_check("t5");
    tick();
    check("t5_idle_valid", 32'(bus.out_valid), 32'd0);
    check("t5_idle_ready", 32'(bus.in_ready), 32'd1);

    // T6: back-to-back stream, one output every 2 cycles
    t6_pc[0] = 32'h300; t6_rs1[0] = 5'd3; t6_rs2[0] = 5'd4; t6_a[0] = 32'h11;   t6_b[0] = 32'hBEEF;
    t6_pc[1] = 32'h304; t6_rs1[1] = 5'd7; t6_rs2[1] = 5'd3; t6_a[1] = 32'h77;   t6_b[1] = 32'h11;
    t6_pc[2] = 32'h308; t6_rs1[2] = 5'd4; t6_rs2[2] = 5'd7; t6_a[2] = 32'hBEEF; t6_b[2] = 32'h77;
    k = 0;
    cyc = 0;
    last = -1;
    n_out = 0;
    while (n_out < 3 && cyc < 30) begin
      if (k < 3) present(t6_pc[k], t6_rs1[k], t6_rs2[k], 5'(k + 1));
      else bus.in_valid = 1'b0;
      #1;
      if (bus.out_valid === 1'b1) begin
        pop_check("t6");
        if (last >= 0) check("t6_gap", 32'(cyc - last), 32'd2);
        last = cyc;
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        push_exp(t6_pc[k], 5'(k + 1), t6_a[k], t6_b[k]);
        k++;
      end
      tick();
      cyc++;
    end
    bus.in_valid = 1'b0;
    check("t6_count", 32'(n_out), 32'd3);

    // T7: reset pulse mid-WAIT drops the instruction
    present(32'h400, 5'd3, 5'd4, 5'd12);
    #1;
    tick();
    bus.in_valid = 1'b0;
    check("t7_wait_busy", 32'(bus.in_ready), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t7_rst_valid", 32'(bus.out_valid), 32'd0);
    check("t7_rst_ready", 32'(bus.in_ready), 32'd1);
    check("t7_rst_pc", bus.out_pc, 32'd0);
    check("t7_rst_rd", 32'(bus.out_rd), 32'd0);
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t7_no_output", 32'(bus.out_valid), 32'd0);
    end

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Operand-fetch stage between decode and execute.
- Accepts one decoded instruction per handshake and drives the register-file read addresses.
- Register file has a 1-cycle synchronous read and skips the read on any cycle with a non-x0 write, so this block retries suppressed reads.
- Forwards same-cycle writeback data and presents registered operands to execute with valid/ready.

Parameters:
XLEN, 32, data width of operands and writeback data
REG_AW, 5, register address width (32 registers)

Ports:
clock  in  1  system clock; all state on rising edge
reset_n  in  1  reset, asynchronous active-low
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  instruction PC
in_rs1  in  REG_AW  source 1 index
in_rs2  in  REG_AW  source 2 index
in_rd  in  REG_AW  destination index, passed through
rf_addr_rs1  out  REG_AW  register-file read address 1
rf_addr_rs2  out  REG_AW  register-file read address 2
rf_data_rs1  in  XLEN  register-file read data 1
rf_data_rs2  in  XLEN  register-file read data 2
wb_valid  in  1  writeback writes this cycle (same signal as the register-file write enable)
wb_rd  in  REG_AW  writeback destination
wb_data  in  XLEN  writeback data
out_valid  out  1  operands valid for execute
out_ready  in  1  execute accepts
out_pc  out  XLEN  registered PC
out_rd  out  REG_AW  registered rd
out_rs1_data  out  XLEN  registered operand 1
out_rs2_data  out  XLEN  registered operand 2

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - reset_n is asynchronous, active-low; deassertion is synchronised externally.
  - Reset values: state=IDLE, out_valid=0, out_pc/out_rd/out_rs*_data=0, held rs1/rs2=0, supp=0, in_ready=1.
- Definitions:
  - wr_now = wb_valid && (wb_rd != 0).
  - supp = flop of wr_now, captured on every edge where the block presents addresses to the register file.
- FSM states: IDLE, WAIT, VALID.
- in_ready = (state==IDLE) || (state==VALID && out_ready). Combinational.
- Accept = in_valid && in_ready:
  - Latch pc, rd, rs1, rs2.
  - Next state = WAIT.
- Read addresses:
  - On an accept cycle, rf_addr_rs* = in_rs*.
  - Otherwise rf_addr_rs* = held rs*.
- WAIT, supp=1:
  - The previous read was skipped by the register file.
  - Re-present held addresses, recompute supp, stay in WAIT.
  - No bound on retries; an uninterrupted writeback stream stalls the stage.
- WAIT, supp=0:
  - Capture each operand as follows, in priority order:
    - held rs==0 → 0.
    - else wr_now && wb_rd==held rs → wb_data (forwarded; rf_data still holds the old value).
    - else rf_data.
  - Next state = VALID.
- Latency: accept in cycle A → out_valid in cycle A+2 when no retry. Each retry adds 1 cycle.
- VALID:
  - out_valid=1.
  - Every cycle, snoop writeback: if wr_now && wb_rd==held rs (non-zero), overwrite that operand with wb_data.
  - Snoop applies to both operands independently, including rs1==rs2.
- VALID && out_ready:
  - With accept → WAIT (2-cycle initiation interval).
  - Without accept → IDLE, out_valid=0.
- Outputs stay stable while out_valid && !out_ready, except for snoop updates to operands.
- Reset asserted mid-operation drops the in-flight instruction. No partial output.

Optional Feature:
- Macro: OPFETCH_PERF_EN.
- Defined:
  - Adds output perf_retry_count [31:0], reset 0.
  - Increments by 1 on every WAIT cycle with supp=1.
  - Saturates at 32'hFFFFFFFF.
- Undefined:
  - Port and counter absent.
  - Functional behaviour identical.

Decomposition:
- Shared package cpu_pkg:
  - XLEN and REG_AW constants.
  - Enumeration opf_state_t {IDLE, WAIT, VALID}.
  - REG_ZERO constant (5'd0).
- One sub-module, opf_operand_sel: per-operand priority mux (x0 / writeback forward / rf data).
  - Instantiated twice for capture.
  - Reused for the snoop path.

Test Plan:
- Reset, then accept pc=0x100, rs1=3, rs2=4, rd=5; RF returns 0x11, 0x22; no wb → out_valid at A+2, out_rs1_data=0x11, out_rs2_data=0x22, out_rd=5.
- Accept with wb_valid=1, wb_rd=7 in cycle A → one retry; out_valid at A+3; perf_retry_count=1 when OPFETCH_PERF_EN.
- rs1=rs2=9; wb writes x9=0xDEAD in the capture cycle → both operands 0xDEAD, not the stale RF value.
- rs1=0; wb writes x0=0xFFFF; RF returns garbage on port 1 → out_rs1_data=0, no retry.
- Hold out_ready=0 in VALID for 3 cycles; wb writes rs2 index with 0xBEEF → out_rs2_data=0xBEEF, pc/rd unchanged; release → IDLE.
- Back-to-back in_valid with out_ready=1 → one output every 2 cycles; reset_n pulse mid-WAIT → out_valid=0 immediately, in_ready=1.
